// File: rtl/boot_uart_loader.sv
// Boot loader: parses SYNC/address/length/data frames from the boot UART and issues word writes.
// Define BOOT_UART_LOADER_CHECKSUM_EN to add a trailing 8-bit sum byte checked after the data.
module boot_uart_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
    , CSUM = 3'd4
`endif
  } state_t;

`ifdef BOOT_UART_LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
  logic [7:0] sum;
`else
  localparam state_t FIN = IDLE;
`endif

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [31:0] shreg, base, cnt, tmo, word;
  logic        sync_hit, collect, byte_last, tmo_exp;
  logic        we_set, done_set, err_set;

  // Little-endian assembly: each new byte enters at the top, so byte 0 ends up in [7:0].
  assign word      = {byte_data, shreg[31:8]};
  assign sync_hit  = (state == IDLE) && byte_valid && (byte_data == SYNC_BYTE);
  assign collect   = byte_valid && ((state == ADDR) || (state == LEN) || (state == DATA));
  assign byte_last = collect && (idx == 2'd3);
  // A byte arriving while the counter sits at 0 still counts; expiry needs a silent cycle.
  assign tmo_exp   = (state != IDLE) && !byte_valid && (tmo == 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sync_hit) state_nxt = ADDR;
      ADDR: if (byte_last) state_nxt = LEN;
      LEN:  if (byte_last) state_nxt = (word == 32'd0) ? FIN : DATA;
      DATA: if (byte_last && (cnt == 32'd1)) state_nxt = FIN;
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
      CSUM: if (byte_valid) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (tmo_exp) state_nxt = IDLE;
  end

  always_comb begin
    busy     = (state != IDLE);
    we_set   = (state == DATA) && byte_last;
    done_set = 1'b0;
    err_set  = tmo_exp;
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
    if ((state == CSUM) && byte_valid) begin
      if (byte_data == sum) done_set = 1'b1;
      else                  err_set  = 1'b1;
    end
`else
    if ((state == LEN) && byte_last && (word == 32'd0)) done_set = 1'b1;
    if (we_set && (cnt == 32'd1))                       done_set = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      done      <= 1'b0;
      error     <= 1'b0;
      idx       <= 2'd0;
      shreg     <= 32'd0;
      base      <= 32'd0;
      cnt       <= 32'd0;
      tmo       <= TMO_LOAD;
    end else begin
      mem_we <= we_set;
      done   <= done_set;
      if (err_set)       error <= 1'b1;
      else if (sync_hit) error <= 1'b0;
      if ((state == IDLE) || byte_valid) tmo <= TMO_LOAD;
      else if (tmo != 32'd0)             tmo <= tmo - 32'd1;
      if (sync_hit) idx <= 2'd0;
      else if (collect) begin
        idx   <= idx + 2'd1;
        shreg <= word;
      end
      if ((state == ADDR) && byte_last) base <= {word[31:2], 2'b00};
      if ((state == LEN) && byte_last)  cnt  <= word;
      // base doubles as the next write address so mem_addr only moves on a write
      if (we_set) begin
        mem_addr  <= base;
        mem_wdata <= word;
        base      <= base + 32'd4;
        cnt       <= cnt - 32'd1;
      end
    end
  end

`ifdef BOOT_UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               sum <= 8'd0;
    else if (sync_hit)                       sum <= 8'd0;
    else if ((state == DATA) && byte_valid)  sum <= sum + byte_data;
  end
`endif

endmodule

// File: tb/tb_boot_uart_loader.sv
// Randomized and directed bench for boot_uart_loader against a frame-parsing reference model.
// Honours BOOT_UART_LOADER_CHECKSUM_EN the same way as the design.
module tb_boot_uart_loader;
  localparam int         TMO  = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0, reset = 1'b1, byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int nchk = 0, nerr = 0;
  int cyc = 0, we_cyc = -1, done_cyc = -2, done_cnt = 0, viol = 0;
  logic err_prev = 1'b0;
  logic [31:0] got_addr[$], got_data[$], ex_addr[$], ex_data[$];
  int   ex_done;
  logic ex_err;
  logic [7:0] s_byte[$];
  int         s_gap[$];

  boot_uart_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error && !err_prev && (mem_we || done)) viol++;
    err_prev = error;
  end

  task automatic clear_mon();
    got_addr.delete(); got_data.delete();
    done_cnt = 0; we_cyc = -1; done_cyc = -2;
  endtask

  // gap = idle clock edges before the byte is sampled
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1; byte_data = b;
    @(negedge clk);
    byte_valid = 1'b0; byte_data = 8'h00;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i], 1);
  endtask

  task automatic get_word(inout int i, output logic [31:0] w, output bit ok);
    ok = 1'b1; w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (i >= s_byte.size() || s_gap[i] > TMO) begin ok = 1'b0; return; end
      w[8*k +: 8] = s_byte[i];
      i++;
    end
  endtask

  // Reference: walk the stream frame by frame; a frame byte arriving after more than TMO
  // silent edges (or never, given the long tail) aborts the frame with error.
  task automatic model_run();
    int i = 0;
    bit ok;
    logic [31:0] a, n, w;
    logic [7:0]  s;
    ex_addr.delete(); ex_data.delete(); ex_done = 0; ex_err = 1'b0;
    while (i < s_byte.size()) begin
      if (s_byte[i] != SYNC) begin i++; continue; end
      i++; ex_err = 1'b0; s = 8'd0;
      get_word(i, a, ok);
      if (!ok) begin ex_err = 1'b1; continue; end
      a = {a[31:2], 2'b00};
      get_word(i, n, ok);
      if (!ok) begin ex_err = 1'b1; continue; end
      while (n != 0) begin
        get_word(i, w, ok);
        if (!ok) break;
        ex_addr.push_back(a); ex_data.push_back(w);
        s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
        a = a + 32'd4; n = n - 32'd1;
      end
      if (!ok) begin ex_err = 1'b1; continue; end
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
      if (i >= s_byte.size() || s_gap[i] > TMO) begin ex_err = 1'b1; continue; end
      if (s_byte[i] == s) ex_done++;
      else                ex_err = 1'b1;
      i++;
`else
      ex_done++;
`endif
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nchk++; if (mem_we !== 1'b0)     begin nerr++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    nchk++; if (done !== 1'b0)       begin nerr++; $display("FAIL reset_done: got %b expected 0", done); end
    nchk++; if (error !== 1'b0)      begin nerr++; $display("FAIL reset_error: got %b expected 0", error); end
    nchk++; if (busy !== 1'b0)       begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nchk++; if (mem_addr !== 32'd0)  begin nerr++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    nchk++; if (mem_wdata !== 32'd0) begin nerr++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    logic [7:0] q[$];
    clear_mon();
    q = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
         8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
    q.push_back(8'h64);
`endif
    send_bytes(q);
    repeat (4) @(negedge clk);
    nchk++;
    if (got_addr.size() != 2) begin nerr++; $display("FAIL basic_nwrites: got %0d expected 2", got_addr.size()); end
    else begin
      nchk++; if (got_addr[0] !== 32'h00001000) begin nerr++; $display("FAIL basic_addr0: got %h expected 00001000", got_addr[0]); end
      nchk++; if (got_data[0] !== 32'h44332211) begin nerr++; $display("FAIL basic_data0: got %h expected 44332211", got_data[0]); end
      nchk++; if (got_addr[1] !== 32'h00001004) begin nerr++; $display("FAIL basic_addr1: got %h expected 00001004", got_addr[1]); end
      nchk++; if (got_data[1] !== 32'h88776655) begin nerr++; $display("FAIL basic_data1: got %h expected 88776655", got_data[1]); end
    end
    nchk++; if (done_cnt != 1)  begin nerr++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
    nchk++; if (error !== 1'b0) begin nerr++; $display("FAIL basic_error: got %b expected 0", error); end
    nchk++; if (busy !== 1'b0)  begin nerr++; $display("FAIL basic_busy: got %b expected 0", busy); end
`ifndef BOOT_UART_LOADER_CHECKSUM_EN
    nchk++; if (done_cyc != we_cyc) begin nerr++; $display("FAIL basic_done_with_we: got cycle %0d expected %0d", done_cyc, we_cyc); end
`endif
  endtask

  task automatic test_zero_len();
    logic [7:0] q[$];
    clear_mon();
    q = {8'h00, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
    q.push_back(8'h00);
`endif
    send_bytes(q);
    repeat (4) @(negedge clk);
    nchk++; if (got_addr.size() != 0) begin nerr++; $display("FAIL zero_nwrites: got %0d expected 0", got_addr.size()); end
    nchk++; if (done_cnt != 1)        begin nerr++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
    nchk++; if (busy !== 1'b0)        begin nerr++; $display("FAIL zero_busy: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    logic [7:0] q[$];
    clear_mon();
    q = {8'hA5, 8'h01, 8'h00};
    send_bytes(q);
    repeat (TMO) @(negedge clk);
    nchk++; if (busy !== 1'b1)  begin nerr++; $display("FAIL tmo_edge_busy: got %b expected 1", busy); end
    nchk++; if (error !== 1'b0) begin nerr++; $display("FAIL tmo_edge_error: got %b expected 0", error); end
    @(negedge clk);
    nchk++; if (error !== 1'b1) begin nerr++; $display("FAIL tmo_error: got %b expected 1", error); end
    nchk++; if (busy !== 1'b0)  begin nerr++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    nchk++; if (got_addr.size() != 0 || done_cnt != 0) begin
      nerr++; $display("FAIL tmo_quiet: got writes=%0d done=%0d expected 0 0", got_addr.size(), done_cnt);
    end
    send_byte(8'hA5, 1);
    nchk++; if (error !== 1'b0) begin nerr++; $display("FAIL tmo_clear: got %b expected 0", error); end
    nchk++; if (busy !== 1'b1)  begin nerr++; $display("FAIL tmo_resync_busy: got %b expected 1", busy); end
    q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
    q.push_back(8'h00);
`endif
    send_bytes(q);
    repeat (2) @(negedge clk);
    nchk++; if (done_cnt != 1) begin nerr++; $display("FAIL tmo_recover_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_exact_expiry();
    clear_mon();
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1); send_byte(8'h20, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h01, TMO); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    send_byte(8'h01, TMO); send_byte(8'h02, 1); send_byte(8'h03, TMO); send_byte(8'h04, 1);
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
    send_byte(8'h0A, TMO);
`endif
    repeat (4) @(negedge clk);
    nchk++; if (error !== 1'b0) begin nerr++; $display("FAIL exact_error: got %b expected 0", error); end
    nchk++; if (done_cnt != 1)  begin nerr++; $display("FAIL exact_done: got %0d expected 1", done_cnt); end
    nchk++;
    if (got_addr.size() != 1) begin nerr++; $display("FAIL exact_nwrites: got %0d expected 1", got_addr.size()); end
    else begin
      nchk++; if (got_addr[0] !== 32'h00002000 || got_data[0] !== 32'h04030201) begin
        nerr++; $display("FAIL exact_write: got %h/%h expected 00002000/04030201", got_addr[0], got_data[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] q[$];
    clear_mon();
    q = {8'hA5, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
    send_bytes(q);
    reset = 1'b1;
    #1;
    nchk++; if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      nerr++; $display("FAIL midrst_flags: got busy=%b we=%b done=%b err=%b expected 0 0 0 0", busy, mem_we, done, error);
    end
    nchk++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      nerr++; $display("FAIL midrst_bus: got %h/%h expected 0/0", mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_byte(8'h03, 1); send_byte(8'h04, 1);
    repeat (TMO + 10) @(negedge clk);
    nchk++; if (got_addr.size() != 0 || done_cnt != 0) begin
      nerr++; $display("FAIL midrst_quiet: got writes=%0d done=%0d expected 0 0", got_addr.size(), done_cnt);
    end
    nchk++; if (busy !== 1'b0 || error !== 1'b0) begin
      nerr++; $display("FAIL midrst_idle: got busy=%b err=%b expected 0 0", busy, error);
    end
  endtask

`ifdef BOOT_UART_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] q[$];
    clear_mon();
    q = {8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
         8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    send_bytes(q);
    repeat (3) @(negedge clk);
    nchk++; if (got_addr.size() != 1 || got_data[0] !== 32'h04030201) begin
      nerr++; $display("FAIL csum_bad_write: got n=%0d expected one write of 04030201", got_addr.size());
    end
    nchk++; if (error !== 1'b1 || done_cnt != 0) begin
      nerr++; $display("FAIL csum_bad: got err=%b done=%0d expected 1 0", error, done_cnt);
    end
    clear_mon();
    q[13] = 8'h0A;
    send_bytes(q);
    repeat (3) @(negedge clk);
    nchk++; if (error !== 1'b0 || done_cnt != 1) begin
      nerr++; $display("FAIL csum_good: got err=%b done=%0d expected 0 1", error, done_cnt);
    end
  endtask
`endif

  function automatic int pick_gap();
    int r = $urandom_range(0, 19);
    if (r == 0) return TMO + 1 + $urandom_range(0, 4);
    if (r == 1) return TMO;
    return $urandom_range(0, 3);
  endfunction

  task automatic gen_stream();
    logic [7:0] b, s;
    logic [31:0] n;
    s_byte.delete(); s_gap.delete();
    for (int f = 0; f < 4; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h5A;
        s_byte.push_back(b); s_gap.push_back(pick_gap());
      end
      s_byte.push_back(SYNC); s_gap.push_back(pick_gap());
      for (int k = 0; k < 4; k++) begin s_byte.push_back(8'($urandom_range(0, 255))); s_gap.push_back(pick_gap()); end
      n = 32'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin s_byte.push_back(n[8*k +: 8]); s_gap.push_back(pick_gap()); end
      s = 8'd0;
      for (int k = 0; k < 4 * int'(n); k++) begin
        b = 8'($urandom_range(0, 255));
        s = s + b;
        s_byte.push_back(b); s_gap.push_back(pick_gap());
      end
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
      s_byte.push_back(($urandom_range(0, 3) == 0) ? s + 8'd1 : s); s_gap.push_back(pick_gap());
`endif
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      gen_stream();
      model_run();
      clear_mon();
      for (int i = 0; i < s_byte.size(); i++) send_byte(s_byte[i], s_gap[i]);
      repeat (TMO + 50) @(negedge clk);
      nchk++;
      if (got_addr.size() != ex_addr.size()) begin
        nerr++; $display("FAIL rnd%0d_nwrites: got %0d expected %0d", r, got_addr.size(), ex_addr.size());
      end
      for (int i = 0; i < got_addr.size() && i < ex_addr.size(); i++) begin
        nchk++; if (got_addr[i] !== ex_addr[i] || got_data[i] !== ex_data[i]) begin
          nerr++; $display("FAIL rnd%0d_write%0d: got %h/%h expected %h/%h", r, i, got_addr[i], got_data[i], ex_addr[i], ex_data[i]);
        end
      end
      nchk++; if (done_cnt != ex_done) begin nerr++; $display("FAIL rnd%0d_done: got %0d expected %0d", r, done_cnt, ex_done); end
      nchk++; if (error !== ex_err)    begin nerr++; $display("FAIL rnd%0d_error: got %b expected %b", r, error, ex_err); end
      nchk++; if (busy !== 1'b0)       begin nerr++; $display("FAIL rnd%0d_busy: got %b expected 0", r, busy); end
    end
    nchk++; if (viol != 0) begin nerr++; $display("FAIL error_overlap: got %0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_zero_len();
    test_timeout();
    test_exact_expiry();
    test_reset_mid_frame();
`ifdef BOOT_UART_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
